window_gen: RTL and testbench

Parametrised K×K sliding-window generator feeding the convolution array. Accepts a raster-order pixel stream, one pixel per handshake, for a frame whose width and height are selected at run time, and emits the complete K×K neighbourhood each time a pixel completes a valid (non-padded) window. It replaces the fixed 5-tap column shifter with internal line buffers, row/column tracking, an explicit valid flag, a frame-done flag and a runtime frame size. This lets one instance serve both the 28×28 input layer and the 12×12 pooled layer.

---
 rtl/window_gen_if.sv | 44 ++++
 rtl/window_gen.sv | 157 +++++++++++++++
 tb/tb_window_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// ---------------------------------------------------------------------------
// window_gen_if
// Bundles the control, pixel-stream and window-output signals of window_gen.
//   start      one-cycle pulse that begins a frame; img_w/img_h sampled with it
//   img_w      frame width  (K..MAX_W legal)
//   img_h      frame height (K..MAX_H legal)
//   in_valid   din carries a pixel this cycle
//   din        pixel, raster order
//   in_ready   high while a frame is active; accept = in_valid & in_ready
//   out_valid  one-cycle pulse, win holds a new window
//   win        K*K window, element (r,c) at win[(r*K+c)*DW +: DW]
//   busy       frame in progress
//   frame_done one-cycle pulse alongside the last window of a frame
//   err        one-cycle pulse, start rejected for an illegal size
// Modports: master drives the stream (producer side), slave is the generator.
// ---------------------------------------------------------------------------
interface window_gen_if #(
  parameter int DW    = 8,
  parameter int K     = 5,
  parameter int MAX_W = 28,
  parameter int MAX_H = 28
) ();
  logic                         start;
  logic [$clog2(MAX_W+1)-1:0]   img_w;
  logic [$clog2(MAX_H+1)-1:0]   img_h;
  logic                         in_valid;
  logic [DW-1:0]                din;
  logic                         in_ready;
  logic                         out_valid;
  logic [K*K*DW-1:0]            win;
  logic                         busy;
  logic                         frame_done;
  logic                         err;

  modport master (
    output start, img_w, img_h, in_valid, din,
    input  in_ready, out_valid, win, busy, frame_done, err
  );

  modport slave (
    input  start, img_w, img_h, in_valid, din,
    output in_ready, out_valid, win, busy, frame_done, err
  );
endinterface

// File: rtl/window_gen.sv
// ---------------------------------------------------------------------------
// window_gen
// K x K sliding-window generator for a raster pixel stream with a run-time
// frame size. K-1 line buffers hold the previous rows; a K x K register
// window shifts left on every accepted pixel. A window is emitted (registered,
// one cycle after the completing accept) whenever the accepted pixel sits at
// row >= K-1 and col >= K-1, i.e. it is the bottom-right element.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   window_gen_if.slave (start/size, pixel stream, window output, status)
// ---------------------------------------------------------------------------
module window_gen #(
  parameter int DW    = 8,
  parameter int K     = 5,
  parameter int MAX_W = 28,
  parameter int MAX_H = 28
) (
  input  logic        clk,
  input  logic        rstn,
  window_gen_if.slave bus
);
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [WW-1:0] K_W     = WW'(K);
  localparam logic [WW-1:0] MAX_W_L = WW'(MAX_W);
  localparam logic [WW-1:0] ONE_W   = WW'(1);
  localparam logic [HW-1:0] K_H     = HW'(K);
  localparam logic [HW-1:0] MAX_H_L = HW'(MAX_H);
  localparam logic [HW-1:0] ONE_H   = HW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [WW-1:0] w_q, col;
  logic [HW-1:0] h_q, row;
  logic [AW-1:0] addr;

  // line_buf[0] holds the row just above the current one, line_buf[K-2] the oldest.
  logic [DW-1:0] line_buf  [K-1][MAX_W];
  logic [DW-1:0] shift_q   [K][K];
  logic [DW-1:0] shift_nxt [K][K];

  logic [K*K*DW-1:0] win_nxt, win_q;
  logic              out_valid_q, frame_done_q, err_q;

  logic size_ok, accept, col_last, row_last, win_hit, last_pix;

  assign addr = col[AW-1:0];

  // Control decode and FSM next state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    size_ok   = (bus.img_w >= K_W) && (bus.img_w <= MAX_W_L) &&
                (bus.img_h >= K_H) && (bus.img_h <= MAX_H_L);
    // start wins over a simultaneous pixel, which is dropped.
    accept    = (state == RUN) && bus.in_valid && !bus.start;
    col_last  = (col == w_q - ONE_W);
    row_last  = (row == h_q - ONE_H);
    win_hit   = accept && (col >= K_W - ONE_W) && (row >= K_H - ONE_H);
    last_pix  = accept && col_last && row_last;
    state_nxt = state;
    if (bus.start) begin
      // An illegal start while running aborts the frame.
      state_nxt = size_ok ? RUN : IDLE;
    end else if (last_pix) begin
      state_nxt = IDLE;
    end
  end

  // Next window: shift left, new right column = {line buffers, din}.
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        shift_nxt[r][c] = shift_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      shift_nxt[r][K-1] = line_buf[K-2-r][addr];
    end
    shift_nxt[K-1][K-1] = bus.din;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_nxt[(r*K+c)*DW +: DW] = shift_nxt[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_q          <= '0;
      h_q          <= '0;
      col          <= '0;
      row          <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (bus.start) begin
        col <= '0;
        row <= '0;
        if (size_ok) begin
          w_q <= bus.img_w;
          h_q <= bus.img_h;
        end else begin
          err_q <= 1'b1;
        end
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + ONE_H;
        end else begin
          col <= col + ONE_W;
        end
        if (win_hit) begin
          out_valid_q  <= 1'b1;
          win_q        <= win_nxt;
          frame_done_q <= last_pix;
        end
      end
    end
  end

  // NOTE: the line buffers and shift window have no reset; stale contents are never
  // exposed because a window needs K-1 fresh rows and K fresh columns first.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      shift_q <= shift_nxt;
      line_buf[0][addr] <= bus.din;
      for (int j = 1; j < K - 1; j++) begin
        line_buf[j][addr] <= line_buf[j-1][addr];
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.in_ready   = (state == RUN);
  assign bus.out_valid  = out_valid_q;
  assign bus.win        = win_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_window_gen.sv
// ---------------------------------------------------------------------------
// tb_window_gen
// Self-checking bench for window_gen. A negedge monitor captures every
// emitted window; the driver keeps the frame image and builds the expected
// window list directly from the neighbourhood definition.
// ---------------------------------------------------------------------------
module tb_window_gen;
  localparam int DW    = 8;
  localparam int K     = 5;
  localparam int MAX_W = 28;
  localparam int MAX_H = 28;
  localparam int WW    = $clog2(MAX_W + 1);
  localparam int HW    = $clog2(MAX_H + 1);
  localparam int WINW  = K * K * DW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  window_gen_if #(.DW(DW), .K(K), .MAX_W(MAX_W), .MAX_H(MAX_H)) bus ();

  window_gen #(.DW(DW), .K(K), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- monitor (sole writer of these) ----------------
  logic [WINW-1:0] got_q[$];
  bit              got_fd[$];
  int              got_acc[$];
  int              acc_total = 0;
  int              orphan    = 0;
  int              fd_total  = 0;
  bit              acc_prev  = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      got_q.push_back(bus.win);
      got_fd.push_back(bus.frame_done);
      got_acc.push_back(acc_total);
      if (!acc_prev) orphan++;
    end
    if (bus.frame_done) fd_total++;
    acc_prev = rstn && bus.in_valid && bus.in_ready && !bus.start;
    if (acc_prev) acc_total++;
  end

  // ---------------- driver-side model ----------------
  int              pix [MAX_H][MAX_W];
  logic [WINW-1:0] exp_q[$];
  int              cur_w, cur_h;
  int              seg_base, fd_base, orphan_base, acc_base;

  typedef struct {
    int w;
    int h;
    bit exp_err;
    int exp_win;
  } size_vec_t;

  size_vec_t vt [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.img_w    = '0;
    bus.img_h    = '0;
  endtask

  function automatic int el(input logic [WINW-1:0] v, input int r, input int c);
    return int'(v[(r*K+c)*DW +: DW]);
  endfunction

  // Window whose bottom-right element is pixel (r,c).
  function automatic logic [WINW-1:0] model_win(input int r, input int c);
    logic [WINW-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[(i*K+j)*DW +: DW] = DW'(pix[r-K+1+i][c-K+1+j]);
    return v;
  endfunction

  task automatic fill(input int w, input int h, input bit rnd);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pix[r][c] = rnd ? int'($urandom_range(255)) : ((r*w + c) & 255);
  endtask

  task automatic do_start(input int w, input int h, input bit with_px, input int px,
                          output bit legal);
    legal = (w >= K) && (w <= MAX_W) && (h >= K) && (h <= MAX_H);
    bus.start    = 1'b1;
    bus.img_w    = WW'(w);
    bus.img_h    = HW'(h);
    bus.in_valid = with_px;
    bus.din      = DW'(px);
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("start_in_ready", bus.in_ready, int'(legal));
    check("start_busy", bus.busy, int'(legal));
    check("start_err", bus.err, int'(!legal));
    if (legal) begin
      cur_w = w;
      cur_h = h;
    end
  endtask

  task automatic begin_segment();
    exp_q.delete();
    seg_base    = got_q.size();
    fd_base     = fd_total;
    orphan_base = orphan;
    acc_base    = acc_total;
  endtask

  // Offer the first n pixels of the current frame, optionally with random gaps.
  task automatic stream(input int n, input int gap_pct);
    int r, c;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / cur_w;
      c = idx % cur_w;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.din      = DW'($urandom);
        step();
      end
      bus.in_valid = 1'b1;
      bus.din      = DW'(pix[r][c]);
      step();
      if (r >= K-1 && c >= K-1) exp_q.push_back(model_win(r, c));
    end
    bus.in_valid = 1'b0;
    if (n == cur_w * cur_h) begin
      check("done_busy", bus.busy, 0);
      check("done_in_ready", bus.in_ready, 0);
      check("done_frame_done", bus.frame_done, 1);
      check("done_out_valid", bus.out_valid, 1);
    end
  endtask

  task automatic end_segment(input string name, input int exp_fd);
    int got_n, bad, lim;
    for (int i = 0; i < 4; i++) step();
    got_n = got_q.size() - seg_base;
    check($sformatf("%s_count", name), got_n, exp_q.size());
    bad = 0;
    lim = (got_n < exp_q.size()) ? got_n : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (got_q[seg_base + i] !== exp_q[i]) bad++;
    check($sformatf("%s_bad_windows", name), bad, 0);
    check($sformatf("%s_frame_done", name), fd_total - fd_base, exp_fd);
    if (exp_fd > 0 && got_n > 0)
      check($sformatf("%s_done_on_last", name), int'(got_fd[got_q.size()-1]), 1);
    check($sformatf("%s_orphan", name), orphan - orphan_base, 0);
    check($sformatf("%s_busy_after", name), bus.busy, 0);
  endtask

  initial begin
    bit legal;
    int w, h, px;

    idle_inputs();
    rstn = 1'b0;
    repeat (3) step();
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_err", bus.err, 0);
    check("rst_win_nonzero", int'(bus.win != '0), 0);
    rstn = 1'b1;
    step();

    // Pixels offered while idle are ignored.
    begin_segment();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = DW'(i + 1);
      step();
    end
    bus.in_valid = 1'b0;
    end_segment("idle", 0);
    check("idle_accepts", acc_total - acc_base, 0);

    // Basic 28x28 ramp.
    begin_segment();
    do_start(28, 28, 1'b0, 0, legal);
    fill(28, 28, 1'b0);
    stream(28 * 28, 0);
    end_segment("f28", 1);
    if (got_q.size() > seg_base) begin
      check("f28_first_after_accepts", got_acc[seg_base] - acc_base, 4*28 + 4 + 1);
      check("f28_w00", el(got_q[seg_base], 0, 0), 0);
      check("f28_w04", el(got_q[seg_base], 0, 4), 4);
      check("f28_w22", el(got_q[seg_base], 2, 2), 58);
      check("f28_w44", el(got_q[seg_base], 4, 4), 116);
    end
    check("f28_windows_const", got_q.size() - seg_base, 576);

    // 12x12 ramp straight after.
    begin_segment();
    do_start(12, 12, 1'b0, 0, legal);
    fill(12, 12, 1'b0);
    stream(12 * 12, 0);
    end_segment("f12", 1);
    if (got_q.size() > seg_base) check("f12_w44", el(got_q[seg_base], 4, 4), 52);
    check("f12_windows_const", got_q.size() - seg_base, 64);

    // Same frame with ~50% input gaps.
    begin_segment();
    do_start(12, 12, 1'b0, 0, legal);
    stream(12 * 12, 50);
    end_segment("f12_gap", 1);
    check("f12_gap_windows_const", got_q.size() - seg_base, 64);

    // Size legality table.
    vt[0] = '{4, 28, 1'b1, 0};
    vt[1] = '{29, 28, 1'b1, 0};
    vt[2] = '{28, 4, 1'b1, 0};
    vt[3] = '{28, 29, 1'b1, 0};
    vt[4] = '{0, 0, 1'b1, 0};
    vt[5] = '{5, 5, 1'b0, 1};
    vt[6] = '{6, 5, 1'b0, 2};
    vt[7] = '{5, 7, 1'b0, 3};
    for (int i = 0; i < 8; i++) begin
      begin_segment();
      do_start(vt[i].w, vt[i].h, 1'b0, 0, legal);
      check($sformatf("tbl%0d_err", i), bus.err, int'(vt[i].exp_err));
      step();
      check($sformatf("tbl%0d_err_pulse", i), bus.err, 0);
      check($sformatf("tbl%0d_busy", i), bus.busy, int'(!vt[i].exp_err));
      if (legal) begin
        fill(vt[i].w, vt[i].h, 1'b1);
        stream(vt[i].w * vt[i].h, 0);
      end
      end_segment($sformatf("tbl%0d", i), vt[i].exp_err ? 0 : 1);
      check($sformatf("tbl%0d_windows_const", i), got_q.size() - seg_base, vt[i].exp_win);
    end

    // Illegal start while running aborts the frame.
    begin_segment();
    do_start(12, 12, 1'b0, 0, legal);
    fill(12, 12, 1'b1);
    stream(20, 0);
    do_start(3, 12, 1'b0, 0, legal);
    end_segment("abort", 0);

    // Restart mid row 7 of a 28x28 frame with a simultaneous pixel.
    begin_segment();
    do_start(28, 28, 1'b0, 0, legal);
    fill(28, 28, 1'b0);
    stream(7 * 28 + 14, 0);
    px = pix[7][14];
    do_start(12, 12, 1'b1, px, legal);
    check("restart_no_accept", acc_total - acc_base, 7 * 28 + 14);
    fill(12, 12, 1'b0);
    stream(12 * 12, 0);
    end_segment("restart", 1);

    // Reset in the middle of a frame.
    begin_segment();
    do_start(28, 28, 1'b0, 0, legal);
    fill(28, 28, 1'b1);
    stream(300, 0);
    rstn = 1'b0;
    step();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_frame_done", bus.frame_done, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_win_nonzero", int'(bus.win != '0), 0);
    rstn = 1'b1;
    end_segment("mid_rst", 0);

    begin_segment();
    do_start(28, 28, 1'b0, 0, legal);
    fill(28, 28, 1'b0);
    stream(28 * 28, 0);
    end_segment("post_rst", 1);
    check("post_rst_windows_const", got_q.size() - seg_base, 576);

    // Randomized frames: random legal size, random data, random gaps.
    for (int i = 0; i < 4; i++) begin
      w = int'($urandom_range(MAX_W, K));
      h = int'($urandom_range(MAX_H, K));
      begin_segment();
      do_start(w, h, 1'b0, 0, legal);
      fill(w, h, 1'b1);
      stream(w * h, int'($urandom_range(60)));
      end_segment($sformatf("rnd%0d", i), 1);
      check($sformatf("rnd%0d_windows_formula", i), got_q.size() - seg_base,
            (w - K + 1) * (h - K + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
